// File: rtl/ghost_sprite_engine.sv
// ghost_sprite_engine: 3-stage multi-ghost sprite pixel pipeline with frill animation.
// Defining GHOST_FLASH_EN adds white/red flashing for frightened ghosts that request it.
module ghost_sprite_engine #(
  parameter int NUM_GHOSTS   = 4,
  parameter int ANIM_PERIOD  = 8,
  parameter int FLASH_PERIOD = 16,
  parameter int COORD_W      = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pix_valid,
  input  logic [COORD_W-1:0]            xpos,
  input  logic [COORD_W-1:0]            ypos,
  input  logic                          frame_start,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_xloc,
  input  logic [NUM_GHOSTS*COORD_W-1:0] ghost_yloc,
  input  logic [NUM_GHOSTS*2-1:0]       ghost_color,
  input  logic [NUM_GHOSTS*2-1:0]       ghost_dir,
  input  logic [NUM_GHOSTS*2-1:0]       ghost_mode,
  input  logic [NUM_GHOSTS-1:0]         flash_req,
  output logic [9:0]                    rom_addr,
  input  logic [2:0]                    rom_data,
  output logic                          out_valid,
  output logic                          hit,
  output logic [2:0]                    ghost_id,
  output logic [7:0]                    color
);
  localparam logic [COORD_W-1:0] C7 = COORD_W'(7);
  localparam logic [COORD_W-1:0] C8 = COORD_W'(8);
  localparam int AW = ANIM_PERIOD > 1 ? $clog2(ANIM_PERIOD) : 1;
  localparam logic [1:0] NORM = 2'b00, FRGT = 2'b01, DEAD = 2'b11;
  localparam logic [7:0] RED = 8'hE0, PNK = 8'hEF, CYN = 8'h1F, ORG = 8'hF4;
  localparam logic [7:0] WHT = 8'hFF, BLU = 8'h03, BLK = 8'h00;

  logic [AW-1:0] anim_cnt;
  logic anim_phase, flash_phase;
  logic [NUM_GHOSTS-1:0] freq;

`ifdef GHOST_FLASH_EN
  localparam int FW = FLASH_PERIOD > 1 ? $clog2(FLASH_PERIOD) : 1;
  logic [FW-1:0] flash_cnt;
  assign freq = flash_req;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      flash_cnt   <= '0;
      flash_phase <= 1'b0;
    end else if (frame_start) begin
      flash_cnt   <= flash_cnt == FW'(FLASH_PERIOD - 1) ? '0 : flash_cnt + 1'b1;
      flash_phase <= flash_phase ^ (flash_cnt == FW'(FLASH_PERIOD - 1));
    end
`else
  logic unused_flash;
  assign freq         = '0;
  assign flash_phase  = 1'b0;
  assign unused_flash = ^flash_req ^ (FLASH_PERIOD == 0);
`endif

  // Phase changes only on frame_start, so it is stable across a whole frame.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      anim_cnt   <= '0;
      anim_phase <= 1'b0;
    end else if (frame_start) begin
      anim_cnt   <= anim_cnt == AW'(ANIM_PERIOD - 1) ? '0 : anim_cnt + 1'b1;
      anim_phase <= anim_phase ^ (anim_cnt == AW'(ANIM_PERIOD - 1));
    end

  logic [COORD_W-1:0] xl, yl;
  logic s0_hit, s0_fl;
  logic [2:0] s0_id;
  logic [3:0] s0_row, s0_col;
  logic [1:0] s0_dir, s0_mode, s0_clr;

  // Scan from the top index down so the lowest covering ghost wins.
  always_comb begin
    xl = '0;
    yl = '0;
    s0_hit = 1'b0;
    s0_fl = 1'b0;
    s0_id = '0;
    s0_row = '0;
    s0_col = '0;
    s0_dir = '0;
    s0_mode = '0;
    s0_clr = '0;
    for (int i = NUM_GHOSTS - 1; i >= 0; i--) begin
      xl = ghost_xloc[i*COORD_W +: COORD_W];
      yl = ghost_yloc[i*COORD_W +: COORD_W];
      if ((xl < C7 || xl - C7 <= xpos) && xpos <= xl + C8 &&
          (yl < C7 || yl - C7 <= ypos) && ypos <= yl + C8) begin
        s0_hit  = 1'b1;
        s0_id   = 3'(i);
        s0_row  = 4'(ypos - yl + C7);
        s0_col  = 4'(xpos - xl + C7);
        s0_dir  = ghost_dir[2*i +: 2];
        s0_mode = ghost_mode[2*i +: 2];
        s0_clr  = ghost_color[2*i +: 2];
        s0_fl   = freq[i +: 1];
      end
    end
  end

  logic s1_v, s1_hit, s1_fl, s2_v, s2_hit, s2_fl;
  logic [2:0] s1_id, s2_id, s2_code;
  logic [3:0] s1_row, s2_row;
  logic [1:0] s1_dir, s1_mode, s1_clr, s2_dir, s2_mode, s2_clr;
  logic fl, rt_up;
  logic [7:0] body, eye, frill, pix_color;

  always_comb begin
    fl    = s2_fl && s2_mode == FRGT && flash_phase;
    rt_up = ~s2_dir[1];
    body  = s2_mode == NORM ? (s2_clr == 2'd0 ? RED : s2_clr == 2'd1 ? PNK : s2_clr == 2'd2 ? CYN : ORG) :
            s2_mode == DEAD ? BLK : fl ? WHT : BLU;
    case (s2_code)
      3'd0:    eye = BLK;
      3'd2:    eye = fl ? RED : WHT;
      3'd3:    eye = rt_up ? WHT : body;
      3'd4:    eye = rt_up ? BLU : body;
      3'd5:    eye = rt_up ? body : WHT;
      3'd6:    eye = rt_up ? body : BLU;
      default: eye = body;
    endcase
    frill     = (s2_code == 3'd1 || s2_code == (anim_phase ? 3'd3 : 3'd2)) ? body : BLK;
    pix_color = !s2_hit ? BLK : s2_row < 4'd12 ? eye : frill;
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1_v <= 1'b0;
      s1_hit <= 1'b0;
      s1_fl <= 1'b0;
      s1_id <= '0;
      s1_row <= '0;
      s1_dir <= '0;
      s1_mode <= '0;
      s1_clr <= '0;
      rom_addr <= '0;
      s2_v <= 1'b0;
      s2_hit <= 1'b0;
      s2_fl <= 1'b0;
      s2_id <= '0;
      s2_row <= '0;
      s2_dir <= '0;
      s2_mode <= '0;
      s2_clr <= '0;
      s2_code <= '0;
      out_valid <= 1'b0;
      hit <= 1'b0;
      ghost_id <= '0;
      color <= '0;
    end else begin
      s1_v <= pix_valid;
      s1_hit <= s0_hit;
      s1_fl <= s0_fl;
      s1_id <= s0_id;
      s1_row <= s0_row;
      s1_dir <= s0_dir;
      s1_mode <= s0_mode;
      s1_clr <= s0_clr;
      rom_addr <= {s0_mode[1] ^ s0_mode[0], ~(s0_mode[1] ^ s0_mode[0]) & (s0_dir[1] ^ s0_dir[0]), s0_row, s0_col};
      s2_v <= s1_v;
      s2_hit <= s1_hit;
      s2_fl <= s1_fl;
      s2_id <= s1_id;
      s2_row <= s1_row;
      s2_dir <= s1_dir;
      s2_mode <= s1_mode;
      s2_clr <= s1_clr;
      s2_code <= rom_data;
      out_valid <= s2_v;
      hit <= s2_hit;
      ghost_id <= s2_id;
      color <= pix_color;
    end
endmodule

// File: doc/ghost_sprite_engine.md
Name: ghost_sprite_engine

Overview:
- Pipelined multi-ghost sprite renderer between the VGA scan counters and the frame compositor.
- Each scanned pixel is tested against NUM_GHOSTS 16x16 ghost boxes; the winning ghost's sprite entry is fetched from an external synchronous sprite ROM.
- The 8-bit RRRGGGBB colour is emitted with fixed latency.
- Frill animation timing is generated internally from frame pulses.
- Optional flash timing is generated internally from frame pulses for frightened ghosts near timeout.

Parameters:
- NUM_GHOSTS, 4, number of ghost channels (1..8); lower index wins overlap.
- ANIM_PERIOD, 8, frames per frill animation phase (>=1).
- FLASH_PERIOD, 16, frames per flash phase (>=1).
- COORD_W, 10, width of screen coordinates.

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- pix_valid  in  1  xpos/ypos valid this cycle
- xpos  in  COORD_W  scan x
- ypos  in  COORD_W  scan y
- frame_start  in  1  one-cycle pulse at start of each frame
- ghost_xloc  in  NUM_GHOSTS*COORD_W  sprite centre x per ghost (bitfield pixel 7,7); ghost i at [i*COORD_W +: COORD_W]
- ghost_yloc  in  NUM_GHOSTS*COORD_W  sprite centre y per ghost
- ghost_color  in  NUM_GHOSTS*2  00 RED, 01 PNK, 10 CYN, 11 ORG
- ghost_dir  in  NUM_GHOSTS*2  00 RT, 01 UP, 10 DN, 11 LT
- ghost_mode  in  NUM_GHOSTS*2  00 NORM, 01 FRGT, 10 SCOR, 11 DEAD
- flash_req  in  NUM_GHOSTS  per-ghost request to flash while FRGT
- rom_addr  out  10  sprite ROM address
- rom_data  in  3  sprite code, valid one cycle after rom_addr
- out_valid  out  1  color/hit valid
- hit  out  1  some ghost covers this pixel
- ghost_id  out  3  index of winning ghost (0 when hit=0)
- color  out  8  pixel colour (BLK when hit=0)

Behaviour:
- Reset: rom_addr=0, out_valid=0, hit=0, ghost_id=0, color=0, all pipeline valids=0, frame counters=0, anim_phase=0, flash_phase=0.
- Behaviour is governed by the clock and reset ports above: one clock, reset asynchronous and active-high. Reset mid-frame drops all in-flight pixels (no out_valid until new pix_valid).
- Stage S0 (combinational on inputs, registered at clk edge):
  - Ghost i covers the pixel if (xloc<7 or xloc-7<=xpos) and xpos<=xloc+8, and likewise for y.
  - The winner is the lowest covering index.
  - row=ypos-yloc+7 and col=xpos-xloc+7, 4 bits each (mod 16).
  - base=0 for NORM/DEAD with RT/LT; base=256 for NORM/DEAD with UP/DN; base=512 for FRGT/SCOR.
  - rom_addr=base+row*16+col is registered with hit, id, row, dir, mode and colour into S1.
  - No hit: rom_addr=0, hit=0.
- Stage S1: rom_data arrives; S1 fields are registered into S2 together with rom_data.
- Stage S2: colour decode, registered to outputs.
- Latency: out_valid equals pix_valid delayed exactly 3 cycles; full throughput, one pixel per clock, no stalls.
- Colours: RED E0, PNK EF, CYN 1F, ORG F4, WHT FF, BLU 03, BLK 00.
- bodycolor: NORM uses the ghost_color table; DEAD uses BLK; FRGT/SCOR use BLU, or WHT when flashing (see the optional feature).
- Eye region (row<12), by code:
  - 0 -> BLK
  - 1 -> body
  - 2 -> WHT
  - 3 -> WHT if dir in {RT,UP}, else body
  - 4 -> BLU if dir in {RT,UP}, else body
  - 5 -> WHT if dir in {LT,DN}, else body
  - 6 -> BLU if dir in {LT,DN}, else body
  - 7 -> body
- Eye colours when flashing (base 512 with WHT body): code 2 -> RED instead of WHT.
- Frill region (row>=12):
  - anim_phase=0: codes 1,2 -> body; all others BLK.
  - anim_phase=1: codes 1,3 -> body; all others BLK.
- Animation timing:
  - On frame_start, anim_cnt increments.
  - When anim_cnt reaches ANIM_PERIOD-1 it wraps to 0 and anim_phase toggles.
  - anim_phase is updated only on frame_start, so it is stable within a frame.
- Coordinate arithmetic is modulo 2^COORD_W; near-zero locations are guarded by the xloc<7 term.

Optional Feature:
- Macro: GHOST_FLASH_EN.
- With the macro defined:
  - flash_cnt advances on frame_start.
  - flash_phase toggles every FLASH_PERIOD frames.
  - A ghost with mode FRGT, flash_req[i]=1 and flash_phase=1 uses body WHT and eyes RED.
- Without the macro: flash_req is ignored, the flash logic is absent, and frightened ghosts are always BLU with WHT eyes.

Test Plan:
- Single ghost 0, xloc=100, yloc=50, NORM, RED, RT; scan (93,43) through (108,58) -> out_valid 3 cycles after each pix_valid; rom_addr at (95,47)=4*16+2=66; ROM code 5 -> colour E0; code 3 -> FF; row 0 -> BLK.
- Ghost 1 UP at (100,50) and ghost 0 at (104,50) overlapping; pixel (102,50) -> ghost_id=0, rom_addr=0+7*16+5=117; pixel (95,50) -> ghost_id=1, rom_addr=256+7*16+2=370.
- FRGT ghost with ROM code 3 at row 14 and ANIM_PERIOD=2; 4 frame_start pulses -> colour alternates 00,03 every 2 frames; code 2 at row 14 gives the opposite phase.
- xloc=3, yloc=3; pixel (0,0) -> hit=1, rom_addr=4*16+4=68; pixel (12,0) -> hit=0, colour 00.
- With GHOST_FLASH_EN, FLASH_PERIOD=1, flash_req[0]=1, FRGT; code 1 -> colour 03 and FF on alternate frames, code 2 -> FF/E0. Without the macro, colour stays 03.
- Assert rst mid-scan with 3 pixels in flight -> out_valid=0 and color=0 immediately; first out_valid exactly 3 cycles after the next pix_valid; anim_phase=0.
